// File: rtl/keypad_password_entry.sv
// Keypad front end: assembles decimal key presses into a password and issues
// registered unlock (e_button) and password-change (rs_button) strobes.
module keypad_password_entry #(
    parameter int MAX_DIGITS  = 5,
    parameter int PW_W        = 17,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            reset_signal,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    output logic [PW_W-1:0] in_password,
    output logic [PW_W-1:0] change_password,
    output logic            e_button,
    output logic            rs_button,
    output logic            entry_error,
    output logic [2:0]      digit_count,
    output logic            busy
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [3:0] KEY_CLEAR  = 4'd10;
    localparam logic [3:0] KEY_ENTER  = 4'd11;
    localparam logic [3:0] KEY_CHANGE = 4'd12;

    typedef enum logic [2:0] {IDLE, ENTRY, CHG_OLD, CHG_NEW, CHG_CONF} state_t;

    state_t            state, state_n;
    logic [PW_W-1:0]   acc, acc_n, old_pw, old_n, new_pw, new_n;
    logic [PW_W-1:0]   in_pw_n, chg_pw_n;
    logic [2:0]        cnt_n;
    logic              e_n, rs_n, err_n;
    logic [TW-1:0]     timer, timer_n;
    logic              accepted;

    assign busy     = (state != IDLE);
    assign accepted = key_valid && (key_code <= KEY_CHANGE);

    always_ff @(posedge clk) begin
        if (!reset_signal) begin
            state           <= IDLE;
            acc             <= '0;
            old_pw          <= '0;
            new_pw          <= '0;
            timer           <= '0;
            digit_count     <= '0;
            in_password     <= '0;
            change_password <= '0;
            e_button        <= 1'b0;
            rs_button       <= 1'b0;
            entry_error     <= 1'b0;
        end else begin
            state           <= state_n;
            acc             <= acc_n;
            old_pw          <= old_n;
            new_pw          <= new_n;
            timer           <= timer_n;
            digit_count     <= cnt_n;
            in_password     <= in_pw_n;
            change_password <= chg_pw_n;
            e_button        <= e_n;
            rs_button       <= rs_n;
            entry_error     <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        old_n    = old_pw;
        new_n    = new_pw;
        cnt_n    = digit_count;
        in_pw_n  = in_password;
        chg_pw_n = change_password;
        e_n      = 1'b0;
        rs_n     = 1'b0;
        err_n    = 1'b0;
        timer_n  = '0;

        // Timeout wins over any key presented in the same cycle.
        if (state != IDLE && timer == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            acc_n   = '0;
            old_n   = '0;
            new_n   = '0;
            cnt_n   = '0;
            err_n   = 1'b1;
        end else begin
            if (state != IDLE)
                timer_n = accepted ? '0 : timer + TW'(1);

            if (key_valid) begin
                if (key_code <= 4'd9) begin
                    if (state == IDLE) begin
                        acc_n   = PW_W'(key_code);
                        cnt_n   = 3'd1;
                        state_n = ENTRY;
                    end else if (digit_count < 3'(MAX_DIGITS)) begin
                        acc_n = acc * PW_W'(10) + PW_W'(key_code);
                        cnt_n = digit_count + 3'd1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (key_code == KEY_CLEAR) begin
                    acc_n = '0;
                    cnt_n = '0;
                end else if (key_code == KEY_CHANGE) begin
                    if (state == IDLE) begin
                        state_n = CHG_OLD;
                        acc_n   = '0;
                        cnt_n   = '0;
                    end
                end else if (key_code == KEY_ENTER) begin
                    if (digit_count == 3'd0) begin
                        err_n = 1'b1;
                    end else begin
                        acc_n = '0;
                        cnt_n = '0;
                        case (state)
                            ENTRY: begin
                                in_pw_n = acc;
                                e_n     = 1'b1;
                                state_n = IDLE;
                            end
                            CHG_OLD: begin
                                old_n   = acc;
                                state_n = CHG_NEW;
                            end
                            CHG_NEW: begin
                                new_n   = acc;
                                state_n = CHG_CONF;
                            end
                            CHG_CONF: begin
                                if (acc == new_pw) begin
                                    in_pw_n  = old_pw;
                                    chg_pw_n = new_pw;
                                    rs_n     = 1'b1;
                                end else begin
                                    err_n = 1'b1;
                                end
                                state_n = IDLE;
                            end
                            default: state_n = IDLE;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_password_entry.sv
// Directed bench for keypad_password_entry: a queue-based entry model is
// checked every cycle, plus literal expectations for the key scenarios.
module tb_keypad_password_entry;
    localparam int MAX_DIGITS  = 5;
    localparam int PW_W        = 17;
    localparam int TIMEOUT_CYC = 1000;

    logic            clk;
    logic            reset_signal;
    logic            key_valid;
    logic [3:0]      key_code;
    logic [PW_W-1:0] in_password;
    logic [PW_W-1:0] change_password;
    logic            e_button;
    logic            rs_button;
    logic            entry_error;
    logic [2:0]      digit_count;
    logic            busy;

    keypad_password_entry #(
        .MAX_DIGITS (MAX_DIGITS),
        .PW_W       (PW_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .reset_signal   (reset_signal),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .in_password    (in_password),
        .change_password(change_password),
        .e_button       (e_button),
        .rs_button      (rs_button),
        .entry_error    (entry_error),
        .digit_count    (digit_count),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: an entry is a list of typed digits; a change request is a list
    // of completed field values (old, new, confirm).
    bit active;
    bit chg_mode;
    int digits[$];
    int fields[$];
    int quiet;
    int exp_in, exp_chg;
    bit exp_e, exp_rs, exp_err;

    task automatic model_step(input bit rst_n, input bit kv, input int kc);
        int v;
        exp_e = 0; exp_rs = 0; exp_err = 0;
        if (!rst_n) begin
            active = 0; chg_mode = 0; quiet = 0;
            digits.delete(); fields.delete();
            exp_in = 0; exp_chg = 0;
            return;
        end
        if (active && quiet == TIMEOUT_CYC - 1) begin
            active = 0; chg_mode = 0; quiet = 0;
            digits.delete(); fields.delete();
            exp_err = 1;
            return;
        end
        if (active) quiet = (kv && kc <= 12) ? 0 : quiet + 1;
        if (!kv || kc > 12) return;
        if (kc <= 9) begin
            if (digits.size() < MAX_DIGITS) begin
                digits.push_back(kc);
                if (!active) begin active = 1; quiet = 0; end
            end else exp_err = 1;
        end else if (kc == 10) begin
            digits.delete();
        end else if (kc == 12) begin
            if (!active) begin
                active = 1; chg_mode = 1; quiet = 0;
                digits.delete(); fields.delete();
            end
        end else begin
            if (digits.size() == 0) exp_err = 1;
            else begin
                v = 0;
                foreach (digits[i]) v = v * 10 + digits[i];
                digits.delete();
                if (!chg_mode) begin
                    exp_in = v; exp_e = 1; active = 0;
                end else begin
                    fields.push_back(v);
                    if (fields.size() == 3) begin
                        if (fields[2] == fields[1]) begin
                            exp_in = fields[0]; exp_chg = fields[1]; exp_rs = 1;
                        end else exp_err = 1;
                        active = 0; chg_mode = 0; quiet = 0;
                        fields.delete();
                    end
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("in_password", 32'(in_password), exp_in);
            cmp("change_password", 32'(change_password), exp_chg);
            cmp("e_button", 32'(e_button), 32'(exp_e));
            cmp("rs_button", 32'(rs_button), 32'(exp_rs));
            cmp("entry_error", 32'(entry_error), 32'(exp_err));
            cmp("digit_count", 32'(digit_count), digits.size());
            cmp("busy", 32'(busy), 32'(active));
        end
    end

    task automatic tick(input bit rst_n, input bit kv, input int kc);
        reset_signal = rst_n;
        key_valid    = kv;
        key_code     = 4'(kc);
        @(posedge clk);
        model_step(rst_n, kv, kc);
        @(negedge clk);
    endtask

    task automatic key(input int kc);
        tick(1'b1, 1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 0);
    endtask

    task automatic keys(input int ks[$]);
        foreach (ks[i]) key(ks[i]);
    endtask

    initial begin
        reset_signal = 1'b0;
        key_valid    = 1'b0;
        key_code     = '0;
        chk_en       = 1'b1;
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b1, 5);
        cmp("reset_busy", 32'(busy), 0);
        cmp("reset_in", 32'(in_password), 0);

        // 1: plain unlock attempt
        keys('{4, 5, 6, 7, 5, 11});
        cmp("t1_in", 32'(in_password), 45675);
        cmp("t1_e", 32'(e_button), 1);
        idle(1);
        cmp("t1_e_off", 32'(e_button), 0);

        // 2: successful change
        keys('{12, 4, 5, 6, 7, 5, 11, 9, 9, 9, 9, 9, 11, 9, 9, 9, 9, 9, 11});
        cmp("t2_rs", 32'(rs_button), 1);
        cmp("t2_in", 32'(in_password), 45675);
        cmp("t2_chg", 32'(change_password), 99999);
        idle(1);
        cmp("t2_rs_off", 32'(rs_button), 0);

        // 3: confirm mismatch
        keys('{12, 1, 2, 11, 8, 8, 8, 8, 8, 11, 8, 8, 8, 8, 7, 11});
        cmp("t3_err", 32'(entry_error), 1);
        cmp("t3_rs", 32'(rs_button), 0);
        cmp("t3_busy", 32'(busy), 0);
        cmp("t3_chg", 32'(change_password), 99999);
        idle(1);

        // 4: sixth digit overflows
        keys('{1, 2, 3, 4, 5, 6});
        cmp("t4_err", 32'(entry_error), 1);
        cmp("t4_cnt", 32'(digit_count), 5);
        key(11);
        cmp("t4_in", 32'(in_password), 12345);
        cmp("t4_e", 32'(e_button), 1);
        idle(1);

        // CLEAR mid-entry, CHANGE ignored outside IDLE, codes 13-15 inert
        keys('{1, 2, 10, 3, 13, 12, 15, 11});
        cmp("clr_in", 32'(in_password), 3);
        cmp("clr_e", 32'(e_button), 1);
        idle(1);

        // 5: timeout, with an ignored code not restarting the timer
        key(7);
        idle(500);
        key(14);
        idle(498);
        cmp("t5_busy_pre", 32'(busy), 1);
        idle(1);
        cmp("t5_err", 32'(entry_error), 1);
        cmp("t5_busy", 32'(busy), 0);
        key(11);
        cmp("t5_enter_err", 32'(entry_error), 1);
        cmp("t5_enter_e", 32'(e_button), 0);

        // key on the timeout cycle is dropped
        key(3);
        idle(TIMEOUT_CYC - 1);
        key(4);
        cmp("to_drop_cnt", 32'(digit_count), 0);
        cmp("to_drop_busy", 32'(busy), 0);
        idle(1);

        // 6: reset aborts entry and overrides a key in the same cycle
        keys('{4, 5});
        tick(1'b0, 1'b1, 7);
        cmp("t6_rst_cnt", 32'(digit_count), 0);
        keys('{9, 11});
        cmp("t6_in", 32'(in_password), 9);
        cmp("t6_e", 32'(e_button), 1);
        idle(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
